// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Port bundle for the RV32 MEM stage: EX/MEM inputs, the
//                single-outstanding data bus, MEM/WB outputs and forwarding.
//                master = the MEM stage itself, slave = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // EX/MEM register contents
    logic              iValid;
    logic              iRegWrite;
    logic              iMemRead;
    logic              iMemWrite;
    logic [2:0]        iFunc3;
    logic [4:0]        iRdAddr;
    logic [XLEN-1:0]   iAluZ;
    logic [XLEN-1:0]   iRs2Val;
    // Pipeline hold
    logic              oStall;
    // Data bus
    logic              oBusReq;
    logic              oBusWe;
    logic [ADDR_W-1:0] oBusAddr;
    logic [3:0]        oBusBe;
    logic [XLEN-1:0]   oBusWdata;
    logic              iBusAck;
    logic              iBusErr;
    logic [XLEN-1:0]   iBusRdata;
    // MEM/WB register
    logic              oWbValid;
    logic              oWbRegWrite;
    logic [4:0]        oWbRdAddr;
    logic [XLEN-1:0]   oWbValue;
    logic              oWbExc;
    // Forwarding to EX
    logic [XLEN-1:0]   oFwMe;
    logic [4:0]        oFwMeRd;
    logic              oFwMeEn;

    modport master (
        input  iValid, iRegWrite, iMemRead, iMemWrite, iFunc3, iRdAddr, iAluZ, iRs2Val,
        output oStall,
        output oBusReq, oBusWe, oBusAddr, oBusBe, oBusWdata,
        input  iBusAck, iBusErr, iBusRdata,
        output oWbValid, oWbRegWrite, oWbRdAddr, oWbValue, oWbExc,
        output oFwMe, oFwMeRd, oFwMeEn
    );

    modport slave (
        output iValid, iRegWrite, iMemRead, iMemWrite, iFunc3, iRdAddr, iAluZ, iRs2Val,
        input  oStall,
        input  oBusReq, oBusWe, oBusAddr, oBusBe, oBusWdata,
        output iBusAck, iBusErr, iBusRdata,
        input  oWbValid, oWbRegWrite, oWbRdAddr, oWbValue, oWbExc,
        input  oFwMe, oFwMeRd, oFwMeEn
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : RV32 MEM stage. Performs loads/stores over a single-
//                outstanding req/ack bus, produces the MEM/WB register and
//                the MEM-stage forwarding path, and stalls upstream while a
//                bus transaction is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic    iClk,
    input  wire logic    iRst,
    mem_stage_if.master  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    state_t            state_q, state_d;

    logic              wb_valid_q,  wb_valid_d;
    logic              wb_rw_q,     wb_rw_d;
    logic [4:0]        wb_rd_q,     wb_rd_d;
    logic [XLEN-1:0]   wb_value_q,  wb_value_d;
    logic              wb_exc_q,    wb_exc_d;
    logic              w_wb_en;

    logic              w_is_mem;
    logic              w_is_load;
    logic [1:0]        w_off;
    logic [1:0]        w_size;
    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_lane;
    logic [XLEN-1:0]   w_load_val;
    logic              w_busy;
    logic              w_stall;

    // Access decode: size, alignment, lane mapping and load extraction.
    // A load with iMemWrite also set is still a load; unknown funct3 codes
    // fall back to a full-word access.
    always_comb begin
        w_is_mem  = bus.iValid & (bus.iMemRead | bus.iMemWrite);
        w_is_load = bus.iMemRead;
        w_off     = bus.iAluZ[1:0];

        w_size = c_SZ_WORD;
        if (w_is_load) begin
            case (bus.iFunc3)
                3'b000, 3'b100: w_size = c_SZ_BYTE;
                3'b001, 3'b101: w_size = c_SZ_HALF;
                default:        w_size = c_SZ_WORD;
            endcase
        end else begin
            case (bus.iFunc3)
                3'b000:  w_size = c_SZ_BYTE;
                3'b001:  w_size = c_SZ_HALF;
                default: w_size = c_SZ_WORD;
            endcase
        end

        w_misaligned = ((w_size == c_SZ_HALF) && w_off[0]) ||
                       ((w_size == c_SZ_WORD) && (w_off != 2'b00));

        case (w_size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.iRs2Val[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{bus.iRs2Val[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.iRs2Val;
            end
        endcase

        // Shift the addressed lane down to bit 0, then extend per funct3[2].
        w_lane = bus.iBusRdata >> {w_off, 3'b000};
        case (w_size)
            c_SZ_BYTE: w_load_val = bus.iFunc3[2] ? {24'd0, w_lane[7:0]}
                                                  : {{24{w_lane[7]}}, w_lane[7:0]};
            c_SZ_HALF: w_load_val = bus.iFunc3[2] ? {16'd0, w_lane[15:0]}
                                                  : {{16{w_lane[15]}}, w_lane[15:0]};
            default:   w_load_val = bus.iBusRdata;
        endcase
    end

    // Next-state, stall and MEM/WB next-value logic.
    // Faulting accesses carry the effective address as their WB value.
    always_comb begin
        state_d    = state_q;
        w_stall    = 1'b0;
        w_wb_en    = 1'b1;
        wb_valid_d = bus.iValid;
        wb_rw_d    = bus.iValid & bus.iRegWrite;
        wb_rd_d    = bus.iRdAddr;
        wb_value_d = bus.iAluZ;
        wb_exc_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_is_mem) begin
                    if (w_misaligned) begin
                        wb_exc_d = 1'b1;
                        wb_rw_d  = 1'b0;
                    end else begin
                        w_stall = 1'b1;
                        w_wb_en = 1'b0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus.iBusAck) begin
                    state_d = S_IDLE;
                    if (bus.iBusErr) begin
                        wb_exc_d = 1'b1;
                        wb_rw_d  = 1'b0;
                    end else if (w_is_load) begin
                        wb_value_d = w_load_val;
                    end
                end else begin
                    w_stall = 1'b1;
                    w_wb_en = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and MEM/WB register; MEM/WB holds while stalled.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_value_q <= '0;
            wb_exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_wb_en) begin
                wb_valid_q <= wb_valid_d;
                wb_rw_q    <= wb_rw_d;
                wb_rd_q    <= wb_rd_d;
                wb_value_q <= wb_value_d;
                wb_exc_q   <= wb_exc_d;
            end
        end
    end

    // Bus fields are derived from the held EX/MEM inputs and are only
    // driven while a request is outstanding.
    always_comb begin
        w_busy        = (state_q == S_BUSY);
        bus.oStall    = w_stall;
        bus.oBusReq   = w_busy;
        bus.oBusWe    = w_busy & ~bus.iMemRead;
        bus.oBusAddr  = w_busy ? {bus.iAluZ[ADDR_W-1:2], 2'b00} : '0;
        bus.oBusBe    = w_busy ? w_be : 4'b0000;
        bus.oBusWdata = w_busy ? w_wdata : '0;
    end

    // MEM/WB outputs and the forwarding path into EX.
    always_comb begin
        bus.oWbValid    = wb_valid_q;
        bus.oWbRegWrite = wb_rw_q;
        bus.oWbRdAddr   = wb_rd_q;
        bus.oWbValue    = wb_value_q;
        bus.oWbExc      = wb_exc_q;
        bus.oFwMe       = wb_value_q;
        bus.oFwMeRd     = wb_rd_q;
        bus.oFwMeEn     = wb_valid_q & wb_rw_q & (wb_rd_q != 5'd0);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed table-driven bench for mem_stage plus hand-written
//                reset-while-busy and stray-ack sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic clk;
    logic rst;

    mem_stage_if #(.XLEN(32), .ADDR_W(32)) bus_if ();

    mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid, regw, mrd, mwr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] aluz, rs2, rdata;
        logic        err;
        int          dly;      // bus cycles without ack before the ack cycle
        logic        e_bus;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        e_wbv, e_wbrw, e_exc;
        logic [31:0] e_val;
        logic        e_fwen;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input int i, input vec_t v, input string ph);
        chk($sformatf("v%0d %s busreq", i, ph), {31'd0, bus_if.oBusReq}, 32'd1);
        chk($sformatf("v%0d %s busaddr", i, ph), bus_if.oBusAddr, v.e_addr);
        chk($sformatf("v%0d %s busbe", i, ph), {28'd0, bus_if.oBusBe}, {28'd0, v.e_be});
        chk($sformatf("v%0d %s buswe", i, ph), {31'd0, bus_if.oBusWe}, {31'd0, v.e_we});
        if (v.e_we)
            chk($sformatf("v%0d %s buswdata", i, ph), bus_if.oBusWdata, v.e_wdata);
    endtask

    initial begin
        //           v  rw rd wr f3      rd  aluz          rs2           rdata         er dl  bus addr         be       wdata         we wbv rw exc val           fw
        vecs[0]  = '{1, 1, 0, 0, 3'b000, 5,  32'h0000_1234, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 1, 0, 32'h0000_1234, 1};
        vecs[1]  = '{0, 0, 0, 0, 3'b000, 0,  32'h0000_5555, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 0, 0, 0, 32'h0,         0};
        vecs[2]  = '{1, 1, 0, 0, 3'b000, 0,  32'h0000_FEED, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 1, 0, 32'h0000_FEED, 0};
        vecs[3]  = '{1, 1, 1, 0, 3'b010, 7,  32'h0000_3001, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 0, 1, 32'h0,         0};
        vecs[4]  = '{1, 0, 0, 1, 3'b001, 0,  32'h0000_2001, 32'h1111,     32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 0, 1, 32'h0,         0};
        vecs[5]  = '{1, 1, 1, 0, 3'b101, 8,  32'h0000_4003, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 0, 1, 32'h0,         0};
        vecs[6]  = '{1, 1, 1, 0, 3'b000, 9,  32'h0000_1003, 32'h0,        32'h80FF_FFFF, 0, 3, 1, 32'h0000_1000, 4'b1000, 32'h0,        0, 1, 1, 0, 32'hFFFF_FF80, 1};
        vecs[7]  = '{1, 0, 0, 1, 3'b001, 0,  32'h0000_2002, 32'hAAAA_5555, 32'h0,        0, 0,  1, 32'h0000_2000, 4'b1100, 32'h5555_5555, 1, 1, 0, 0, 32'h0000_2002, 0};
        vecs[8]  = '{1, 1, 1, 0, 3'b101, 10, 32'h0000_4000, 32'h0,        32'h1234_5678, 1, 1,  1, 32'h0000_4000, 4'b0011, 32'h0,        0, 1, 0, 1, 32'h0,         0};
        vecs[9]  = '{1, 1, 0, 0, 3'b000, 6,  32'h0000_ABCD, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'b0000, 32'h0,        0, 1, 1, 0, 32'h0000_ABCD, 1};
        vecs[10] = '{1, 0, 0, 1, 3'b000, 0,  32'h0000_5001, 32'h1234_5678, 32'h0,        0, 1,  1, 32'h0000_5000, 4'b0010, 32'h7878_7878, 1, 1, 0, 0, 32'h0000_5001, 0};
        vecs[11] = '{1, 1, 1, 0, 3'b010, 3,  32'h0000_6004, 32'h0,        32'hDEAD_BEEF, 0, 0,  1, 32'h0000_6004, 4'b1111, 32'h0,        0, 1, 1, 0, 32'hDEAD_BEEF, 1};
        vecs[12] = '{1, 1, 1, 0, 3'b100, 4,  32'h0000_7002, 32'h0,        32'h11A2_3344, 0, 2,  1, 32'h0000_7000, 4'b0100, 32'h0,        0, 1, 1, 0, 32'h0000_00A2, 1};
        vecs[13] = '{1, 1, 1, 0, 3'b001, 4,  32'h0000_7002, 32'h0,        32'h8001_1234, 0, 0,  1, 32'h0000_7000, 4'b1100, 32'h0,        0, 1, 1, 0, 32'hFFFF_8001, 1};
        vecs[14] = '{1, 0, 0, 1, 3'b100, 0,  32'h0000_8000, 32'hCAFE_F00D, 32'h0,        0, 0,  1, 32'h0000_8000, 4'b1111, 32'hCAFE_F00D, 1, 1, 0, 0, 32'h0000_8000, 0};
        vecs[15] = '{1, 1, 1, 1, 3'b000, 11, 32'h0000_9001, 32'hFFFF_FFFF, 32'h0000_AB00, 0, 0,  1, 32'h0000_9000, 4'b0010, 32'h0,        0, 1, 1, 0, 32'hFFFF_FFAB, 1};
        vecs[16] = '{1, 1, 1, 0, 3'b001, 12, 32'h0000_0000, 32'h0,        32'h0000_7FFF, 0, 0,  1, 32'h0000_0000, 4'b0011, 32'h0,        0, 1, 1, 0, 32'h0000_7FFF, 1};
        vecs[17] = '{1, 1, 0, 1, 3'b001, 13, 32'h0000_A000, 32'h0000_BEEF, 32'h0,        0, 0,  1, 32'h0000_A000, 4'b0011, 32'hBEEF_BEEF, 1, 1, 1, 0, 32'h0000_A000, 1};
    end

    initial begin
        logic prev_wbv;

        rst = 1'b1;
        bus_if.iValid = 1'b0; bus_if.iRegWrite = 1'b0;
        bus_if.iMemRead = 1'b0; bus_if.iMemWrite = 1'b0;
        bus_if.iFunc3 = 3'd0; bus_if.iRdAddr = 5'd0;
        bus_if.iAluZ = 32'd0; bus_if.iRs2Val = 32'd0;
        bus_if.iBusAck = 1'b0; bus_if.iBusErr = 1'b0; bus_if.iBusRdata = 32'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset wbvalid", {31'd0, bus_if.oWbValid}, 32'd0);
        chk("reset wbvalue", bus_if.oWbValue, 32'd0);
        chk("reset busreq", {31'd0, bus_if.oBusReq}, 32'd0);
        chk("reset stall", {31'd0, bus_if.oStall}, 32'd0);
        chk("reset fwen", {31'd0, bus_if.oFwMeEn}, 32'd0);
        chk("reset busbe", {28'd0, bus_if.oBusBe}, 32'd0);
        @(posedge clk); #1;

        prev_wbv = 1'b0;
        for (int i = 0; i < NV; i++) begin
            bus_if.iValid    = vecs[i].valid;
            bus_if.iRegWrite = vecs[i].regw;
            bus_if.iMemRead  = vecs[i].mrd;
            bus_if.iMemWrite = vecs[i].mwr;
            bus_if.iFunc3    = vecs[i].f3;
            bus_if.iRdAddr   = vecs[i].rd;
            bus_if.iAluZ     = vecs[i].aluz;
            bus_if.iRs2Val   = vecs[i].rs2;
            bus_if.iBusAck   = 1'b0;
            bus_if.iBusErr   = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d issue stall", i), {31'd0, bus_if.oStall}, {31'd0, vecs[i].e_bus});
            chk($sformatf("v%0d issue busreq", i), {31'd0, bus_if.oBusReq}, 32'd0);
            if (vecs[i].e_bus) begin
                chk($sformatf("v%0d issue wbhold", i), {31'd0, bus_if.oWbValid}, {31'd0, prev_wbv});
                @(posedge clk); #1;
                for (int k = 0; k < vecs[i].dly; k++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d wait%0d stall", i, k), {31'd0, bus_if.oStall}, 32'd1);
                    chk($sformatf("v%0d wait%0d wbhold", i, k), {31'd0, bus_if.oWbValid}, {31'd0, prev_wbv});
                    chk_bus(i, vecs[i], "wait");
                    @(posedge clk); #1;
                end
                bus_if.iBusAck   = 1'b1;
                bus_if.iBusErr   = vecs[i].err;
                bus_if.iBusRdata = vecs[i].rdata;
                @(negedge clk);
                chk($sformatf("v%0d ack stall", i), {31'd0, bus_if.oStall}, 32'd0);
                chk_bus(i, vecs[i], "ack");
            end
            @(posedge clk); #1;
            bus_if.iBusAck = 1'b0;
            bus_if.iBusErr = 1'b0;
            chk($sformatf("v%0d wbvalid", i), {31'd0, bus_if.oWbValid}, {31'd0, vecs[i].e_wbv});
            chk($sformatf("v%0d fwen", i), {31'd0, bus_if.oFwMeEn}, {31'd0, vecs[i].e_fwen});
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d wbexc", i), {31'd0, bus_if.oWbExc}, {31'd0, vecs[i].e_exc});
                chk($sformatf("v%0d wbregwrite", i), {31'd0, bus_if.oWbRegWrite}, {31'd0, vecs[i].e_wbrw});
                chk($sformatf("v%0d wbrd", i), {27'd0, bus_if.oWbRdAddr}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d fwrd", i), {27'd0, bus_if.oFwMeRd}, {27'd0, vecs[i].rd});
                if (!vecs[i].e_exc) begin
                    chk($sformatf("v%0d wbvalue", i), bus_if.oWbValue, vecs[i].e_val);
                    chk($sformatf("v%0d fwvalue", i), bus_if.oFwMe, vecs[i].e_val);
                end
            end
            prev_wbv = vecs[i].e_wbv;
        end

        // Reset while a load is outstanding, then a stray ack in IDLE.
        bus_if.iValid    = 1'b1;
        bus_if.iRegWrite = 1'b1;
        bus_if.iMemRead  = 1'b1;
        bus_if.iMemWrite = 1'b0;
        bus_if.iFunc3    = 3'b010;
        bus_if.iRdAddr   = 5'd14;
        bus_if.iAluZ     = 32'h0000_B000;
        @(negedge clk);
        chk("rstbusy issue stall", {31'd0, bus_if.oStall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy busreq", {31'd0, bus_if.oBusReq}, 32'd1);
        chk("rstbusy busaddr", bus_if.oBusAddr, 32'h0000_B000);
        rst = 1'b1;
        bus_if.iValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstbusy after busreq", {31'd0, bus_if.oBusReq}, 32'd0);
        chk("rstbusy after wbvalid", {31'd0, bus_if.oWbValid}, 32'd0);
        chk("rstbusy after stall", {31'd0, bus_if.oStall}, 32'd0);
        bus_if.iBusAck   = 1'b1;
        bus_if.iBusRdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus_if.iBusAck = 1'b0;
        @(negedge clk);
        chk("stray ack wbvalid", {31'd0, bus_if.oWbValid}, 32'd0);
        chk("stray ack fwen", {31'd0, bus_if.oFwMeEn}, 32'd0);
        chk("stray ack busreq", {31'd0, bus_if.oBusReq}, 32'd0);
        chk("stray ack stall", {31'd0, bus_if.oStall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
